// File: rtl/pwm_capture.sv
// PWM high-time / period meter. Counts enable ticks between rising edges of a
// synchronised pin and publishes one result per period, or a stuck result on timeout.
module pwm_capture #(
  parameter int CNT_BITWIDTH = 9
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic                    pwm_pin_i,
  output logic [CNT_BITWIDTH-1:0] high_o,
  output logic [CNT_BITWIDTH-1:0] period_o,
  output logic                    valid_o,
  output logic                    stuck_o
);

  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic                    samp_q, samp_d;
  logic [CNT_BITWIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_BITWIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_BITWIDTH-1:0] high_q, high_d;
  logic [CNT_BITWIDTH-1:0] period_q, period_d;
  logic                    stuck_q, stuck_d;
  logic                    valid_q, valid_d;

  logic sync_pin, rise, timeout;

  assign sync_pin = sync_q[1];
  assign rise     = clk_en_i & sync_pin & ~samp_q;
  // An edge on the same tick as a full counter wins over the timeout.
  assign timeout  = clk_en_i & ~rise & (pcnt_q == CNT_MAX);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      samp_q   <= 1'b0;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      stuck_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      samp_q   <= samp_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      stuck_q  <= stuck_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rise)         state_d = MEASURE;
    else if (timeout) state_d = IDLE;
  end

  always_comb begin
    sync_d   = {sync_q[0], pwm_pin_i};
    samp_d   = samp_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    high_d   = high_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    if (clk_en_i) begin
      samp_d = sync_pin;
      if (rise) begin
        // The first edge after idle only opens a period; nothing to publish yet.
        if (state_q == MEASURE) begin
          high_d   = hcnt_q;
          period_d = pcnt_q;
          stuck_d  = 1'b0;
          valid_d  = 1'b1;
        end
        hcnt_d = CNT_ONE;
        pcnt_d = CNT_ONE;
      end else if (timeout) begin
        high_d   = sync_pin ? CNT_MAX : '0;
        period_d = CNT_MAX;
        stuck_d  = 1'b1;
        valid_d  = 1'b1;
        hcnt_d   = '0;
        pcnt_d   = '0;
      end else begin
        pcnt_d = pcnt_q + CNT_ONE;
        if (state_q == MEASURE && sync_pin) hcnt_d = hcnt_q + CNT_ONE;
      end
    end
  end

  assign high_o   = high_q;
  assign period_o = period_q;
  assign stuck_o  = stuck_q;
  assign valid_o  = valid_q;

endmodule
